// File: rtl/axi_time_pkg.sv
// Shared types and helpers for the axi_time blocks: tag FSM states and a
// wrap-safe "has the counter reached this time" test.
package axi_time_pkg;

  localparam int LATE_CNT_W  = 16;
  localparam int MAX_COUNT_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STREAM,
    DROP
  } tag_state_t;

  // Operands are MSB-aligned by the caller, so bit 63 of the difference is the
  // sign of the modular distance whatever the real counter width is.
  function automatic logic time_reached(input logic [MAX_COUNT_W-1:0] counter,
                                        input logic [MAX_COUNT_W-1:0] ts);
    logic [MAX_COUNT_W-1:0] diff;
    diff = counter - ts;
    return ~diff[MAX_COUNT_W-1];
  endfunction

endpackage

// File: rtl/axi_time_cmp.sv
// Combinational wrap-safe launch-time compare: due once the counter has reached
// ts, late once it is more than LATE_MARGIN ticks past it.
module axi_time_cmp
  import axi_time_pkg::*;
#(
  parameter int COUNT_WIDTH = 64,
  parameter int LATE_MARGIN = 0
) (
  input  logic [COUNT_WIDTH-1:0] time_counter,
  input  logic [COUNT_WIDTH-1:0] ts,
  output logic                   due,
  output logic                   late
);

  localparam int ALIGN = MAX_COUNT_W - COUNT_WIDTH;
  localparam logic signed [COUNT_WIDTH-1:0] MARGIN = COUNT_WIDTH'(LATE_MARGIN);

  logic [MAX_COUNT_W-1:0]        counter_al;
  logic [MAX_COUNT_W-1:0]        ts_al;
  logic signed [COUNT_WIDTH-1:0] diff;

  always_comb begin
    counter_al = MAX_COUNT_W'(time_counter) << ALIGN;
    ts_al      = MAX_COUNT_W'(ts) << ALIGN;
    diff       = time_counter - ts;
    due        = time_reached(counter_al, ts_al);
    late       = diff > MARGIN;
  end

endmodule

// File: rtl/axi_time_tag_extract.sv
// Strips the timestamp header from each AXIS packet and releases the payload
// once time_counter reaches the launch time; late packets are flagged or dropped.
module axi_time_tag_extract
  import axi_time_pkg::*;
#(
  parameter int COUNT_WIDTH = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int LATE_MARGIN = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    time_enable,
  input  logic [COUNT_WIDTH-1:0]  time_counter,
  input  logic                    late_drop,
  output logic                    time_running,
  output logic                    time_underrun,
  output logic                    header_error,
  output logic [LATE_CNT_W-1:0]   late_count,
  output logic                    s_axis_ready,
  input  logic                    s_axis_valid,
  input  logic [DATA_WIDTH-1:0]   s_axis_data,
  input  logic [DATA_WIDTH/8-1:0] s_axis_keep,
  input  logic                    s_axis_last,
  input  logic                    m_axis_ready,
  output logic                    m_axis_valid,
  output logic [DATA_WIDTH-1:0]   m_axis_data,
  output logic [DATA_WIDTH/8-1:0] m_axis_keep,
  output logic                    m_axis_last
);

  tag_state_t             state;
  tag_state_t             state_nxt;
  logic [COUNT_WIDTH-1:0] ts_r;
  logic                   first_wait;
  logic                   hdr_accept;
  logic                   hdr_err_set;
  logic                   underrun_set;
  logic                   due;
  logic                   late;

  axi_time_cmp #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .LATE_MARGIN (LATE_MARGIN)
  ) u_cmp (
    .time_counter (time_counter),
    .ts           (ts_r),
    .due          (due),
    .late         (late)
  );

  assign m_axis_data = s_axis_data;
  assign m_axis_keep = s_axis_keep;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      ts_r          <= '0;
      first_wait    <= 1'b0;
      time_underrun <= 1'b0;
      header_error  <= 1'b0;
      late_count    <= '0;
    end else begin
      state         <= state_nxt;
      first_wait    <= hdr_accept;
      time_underrun <= underrun_set;
      header_error  <= hdr_err_set;
      if (hdr_accept) begin
        ts_r <= s_axis_data[COUNT_WIDTH-1:0];
      end
      if (underrun_set && late_count != '1) begin
        late_count <= late_count + LATE_CNT_W'(1);
      end
    end
  end

  // Losing the enable while waiting cancels the packet; that check wins over
  // the lateness decision so a disabled packet is never counted as late.
  always_comb begin
    state_nxt    = state;
    s_axis_ready = 1'b0;
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    time_running = 1'b0;
    hdr_accept   = 1'b0;
    hdr_err_set  = 1'b0;
    underrun_set = 1'b0;

    case (state)
      IDLE: begin
        s_axis_ready = time_enable;
        if (time_enable && s_axis_valid) begin
          if (s_axis_last) begin
            hdr_err_set = 1'b1;
          end else begin
            hdr_accept = 1'b1;
            state_nxt  = WAIT;
          end
        end
      end
      WAIT: begin
        if (!time_enable) begin
          state_nxt = DROP;
        end else if (first_wait && late) begin
          underrun_set = 1'b1;
          state_nxt    = late_drop ? DROP : STREAM;
        end else if (due) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        m_axis_valid = s_axis_valid;
        s_axis_ready = m_axis_ready;
        m_axis_last  = s_axis_last;
        time_running = 1'b1;
        if (s_axis_valid && m_axis_ready && s_axis_last) begin
          state_nxt = IDLE;
        end
      end
      DROP: begin
        s_axis_ready = 1'b1;
        if (s_axis_valid && s_axis_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (!resetn) begin
      s_axis_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_time_tag_extract.sv
// Randomized and directed bench for axi_time_tag_extract, checked every cycle
// against a packet-level timing model derived from launch-time arithmetic.
module tb_axi_time_tag_extract;

  localparam int CW     = 64;
  localparam int DW     = 64;
  localparam int KW     = DW / 8;
  localparam int MARGIN = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef enum int {P_IDLE, P_WAIT, P_STREAM, P_DROP} phase_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          time_enable = 1'b0;
  logic [CW-1:0] time_counter = '0;
  logic          late_drop = 1'b0;
  logic          time_running;
  logic          time_underrun;
  logic          header_error;
  logic [15:0]   late_count;
  logic          s_axis_ready;
  logic          s_axis_valid = 1'b0;
  logic [DW-1:0] s_axis_data = '0;
  logic [KW-1:0] s_axis_keep = '0;
  logic          s_axis_last = 1'b0;
  logic          m_axis_ready = 1'b1;
  logic          m_axis_valid;
  logic [DW-1:0] m_axis_data;
  logic [KW-1:0] m_axis_keep;
  logic          m_axis_last;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     bp_mode = 0;
  bit     timed_out = 0;

  beat_t stim_q[$];
  int    len_q[$];
  beat_t cur_q[$];

  int          out_beats = 0;
  int          und_total = 0;
  int          herr_total = 0;
  logic [63:0] first_cnt = '0;
  bit          pkt_valid_seen = 0;

  axi_time_tag_extract #(
    .COUNT_WIDTH (CW),
    .DATA_WIDTH  (DW),
    .LATE_MARGIN (MARGIN)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .time_enable   (time_enable),
    .time_counter  (time_counter),
    .late_drop     (late_drop),
    .time_running  (time_running),
    .time_underrun (time_underrun),
    .header_error  (header_error),
    .late_count    (late_count),
    .s_axis_ready  (s_axis_ready),
    .s_axis_valid  (s_axis_valid),
    .s_axis_data   (s_axis_data),
    .s_axis_keep   (s_axis_keep),
    .s_axis_last   (s_axis_last),
    .m_axis_ready  (m_axis_ready),
    .m_axis_valid  (m_axis_valid),
    .m_axis_data   (m_axis_data),
    .m_axis_keep   (m_axis_keep),
    .m_axis_last   (m_axis_last)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    time_counter = time_counter + 64'd1;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (bp_mode)
      0:       m_axis_ready = 1'b1;
      1:       m_axis_ready = 1'($urandom_range(0, 1));
      default: m_axis_ready = ~m_axis_ready;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: the release cycle of each packet is computed once at header
  // acceptance from the signed distance between launch time and counter.
  initial begin
    int     mode = 0;
    longint hdr_cyc = 0, rel_cyc = 0, drop_cyc = 0;
    longint und_cyc = -10, herr_cyc = -10;
    longint d1;
    bit     pkt_late = 0;
    int     model_late = 0;
    int     n;
    phase_t ph;
    beat_t  b;
    logic   exp_ready;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mode = 0; model_late = 0; und_cyc = -10; herr_cyc = -10;
        cur_q.delete(); stim_q.delete(); len_q.delete();
        checkOutput("reset_s_axis_ready", 64'(s_axis_ready), 64'd0);
        checkOutput("reset_m_axis_valid", 64'(m_axis_valid), 64'd0);
        checkOutput("reset_time_running", 64'(time_running), 64'd0);
        checkOutput("reset_late_count", 64'(late_count), 64'd0);
        continue;
      end

      if (mode == 0) ph = P_IDLE;
      else if (mode == 2) ph = (cyc >= drop_cyc) ? P_DROP : P_WAIT;
      else ph = (cyc < rel_cyc) ? P_WAIT : P_STREAM;

      if (cyc == und_cyc && model_late != 16'hFFFF) model_late++;
      und_total  += int'(time_underrun);
      herr_total += int'(header_error);
      if (m_axis_valid && !pkt_valid_seen) begin
        first_cnt      = time_counter;
        pkt_valid_seen = 1;
      end

      case (ph)
        P_IDLE:   exp_ready = time_enable;
        P_WAIT:   exp_ready = 1'b0;
        P_STREAM: exp_ready = m_axis_ready;
        default:  exp_ready = 1'b1;
      endcase
      checkOutput("time_underrun", 64'(time_underrun), 64'(cyc == und_cyc));
      checkOutput("header_error", 64'(header_error), 64'(cyc == herr_cyc));
      checkOutput("late_count", 64'(late_count), 64'(model_late));
      checkOutput("s_axis_ready", 64'(s_axis_ready), 64'(exp_ready));
      checkOutput("m_axis_valid", 64'(m_axis_valid), 64'(ph == P_STREAM && s_axis_valid));
      checkOutput("time_running", 64'(time_running), 64'(ph == P_STREAM));

      if (ph == P_WAIT && mode == 1) begin
        if (!time_enable) begin
          mode = 2; drop_cyc = cyc + 1; cur_q.delete();
        end else if (cyc == hdr_cyc + 1 && pkt_late) begin
          und_cyc = cyc + 1;
          if (late_drop) begin
            mode = 2; drop_cyc = cyc + 1; cur_q.delete();
          end
        end
      end

      if (ph == P_STREAM && m_axis_valid && m_axis_ready) begin
        out_beats++;
        if (cur_q.size() == 0) begin
          checkOutput("unexpected_beat", 64'd1, 64'd0);
        end else begin
          b = cur_q.pop_front();
          checkOutput("m_axis_data", m_axis_data, b.data);
          checkOutput("m_axis_keep", 64'(m_axis_keep), 64'(b.keep));
          checkOutput("m_axis_last", 64'(m_axis_last), 64'(b.last));
        end
        if (s_axis_last) mode = 0;
      end else if (ph == P_DROP && s_axis_valid && s_axis_last) begin
        mode = 0;
      end else if (ph == P_IDLE && s_axis_valid && s_axis_ready) begin
        n = (len_q.size() > 0) ? len_q.pop_front() : 0;
        cur_q.delete();
        repeat (n) if (stim_q.size() > 0) cur_q.push_back(stim_q.pop_front());
        if (s_axis_last) begin
          herr_cyc = cyc + 1;
        end else begin
          mode = 1; hdr_cyc = cyc; pkt_valid_seen = 0;
          d1 = longint'(time_counter + 64'd1 - s_axis_data[CW-1:0]);
          pkt_late = d1 > MARGIN;
          rel_cyc  = cyc + 2 + ((d1 >= 0) ? 0 : -d1);
        end
      end
    end
  end

  task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int n = 0;
    s_axis_valid = 1'b1; s_axis_data = d; s_axis_keep = k; s_axis_last = l;
    forever begin
      @(negedge clk);
      if (s_axis_ready) break;
      n++;
      if (n > 3000) begin
        errors++; timed_out = 1;
        $display("[TB] FAIL beat_handshake_timeout: got no ready, expected ready within 3000 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axis_valid = 1'b0; s_axis_last = 1'b0;
  endtask

  // Sends a header carrying ts, then nbeats payload beats (registered with the
  // model first so the scoreboard knows the expected payload).
  task automatic applyStimulus(input logic [CW-1:0] ts, input int nbeats, input logic hdr_last,
                               input int stop_after);
    beat_t bt[$];
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = KW'($urandom);
      b.last = (i == nbeats - 1);
      bt.push_back(b);
      stim_q.push_back(b);
    end
    len_q.push_back(nbeats);
    drive_beat(DW'(ts), KW'($urandom), hdr_last);
    for (int i = 0; i < nbeats && i < stop_after; i++) drive_beat(bt[i].data, bt[i].keep, bt[i].last);
  endtask

  task automatic set_counter(input logic [CW-1:0] v);
    @(posedge clk);
    #2;
    time_counter = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    idle(3);
    resetn = 1'b1;
    idle(1);
  endtask

  task automatic clear_stats();
    out_beats = 0; und_total = 0; herr_total = 0; first_cnt = '0; timed_out = 0;
  endtask

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: got no end of test, expected completion within 1 ms");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    idle(3);
    resetn = 1'b1;
    time_enable = 1'b1;
    idle(2);

    $display("[TB] on-time packet");
    late_drop = 1'b0; bp_mode = 0;
    set_counter(64'd100); clear_stats();
    applyStimulus(64'd110, 4, 1'b0, 4);
    idle(3);
    checkOutput("ontime_first_counter", first_cnt, 64'd111);
    checkOutput("ontime_beats", 64'(out_beats), 64'd4);
    checkOutput("ontime_underruns", 64'(und_total), 64'd0);

    $display("[TB] late packet dropped");
    do_reset();
    late_drop = 1'b1;
    set_counter(64'd500); clear_stats();
    applyStimulus(64'd400, 3, 1'b0, 3);
    idle(3);
    checkOutput("latedrop_beats", 64'(out_beats), 64'd0);
    checkOutput("latedrop_underruns", 64'(und_total), 64'd1);
    checkOutput("latedrop_late_count", 64'(late_count), 64'd1);
    checkOutput("latedrop_consumed", 64'(timed_out), 64'd0);

    $display("[TB] late packet forwarded");
    do_reset();
    late_drop = 1'b0;
    set_counter(64'd500); clear_stats();
    applyStimulus(64'd400, 3, 1'b0, 3);
    idle(3);
    checkOutput("latefwd_beats", 64'(out_beats), 64'd3);
    checkOutput("latefwd_first_counter", first_cnt, 64'd502);
    checkOutput("latefwd_underruns", 64'(und_total), 64'd1);
    checkOutput("latefwd_late_count", 64'(late_count), 64'd1);

    $display("[TB] reset during stream with backpressure");
    bp_mode = 2;
    set_counter(64'd1000); clear_stats();
    applyStimulus(64'd1001, 6, 1'b0, 3);
    checkOutput("rst_beats_before", 64'(out_beats), 64'd3);
    resetn = 1'b0;
    #1;
    checkOutput("rst_async_s_ready", 64'(s_axis_ready), 64'd0);
    checkOutput("rst_async_m_valid", 64'(m_axis_valid), 64'd0);
    checkOutput("rst_async_running", 64'(time_running), 64'd0);
    checkOutput("rst_async_late_count", 64'(late_count), 64'd0);
    idle(3);
    resetn = 1'b1;
    bp_mode = 0;
    idle(2);

    $display("[TB] counter wrap");
    set_counter(64'hFFFF_FFFF_FFFF_FFFE); clear_stats();
    applyStimulus(64'd2, 3, 1'b0, 3);
    idle(3);
    checkOutput("wrap_first_counter", first_cnt, 64'd3);
    checkOutput("wrap_beats", 64'(out_beats), 64'd3);
    checkOutput("wrap_underruns", 64'(und_total), 64'd0);

    $display("[TB] header-only packet, then disable while waiting");
    do_reset(); clear_stats();
    applyStimulus(64'd0, 0, 1'b1, 0);
    set_counter(64'd10);
    fork
      applyStimulus(64'd1000, 2, 1'b0, 2);
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (time_counter < 64'd20 && n < 200);
        @(posedge clk);
        #1;
        time_enable = 1'b0;
      end
    join
    idle(3);
    time_enable = 1'b1;
    idle(2);
    checkOutput("disable_header_errors", 64'(herr_total), 64'd1);
    checkOutput("disable_beats", 64'(out_beats), 64'd0);
    checkOutput("disable_underruns", 64'(und_total), 64'd0);
    checkOutput("disable_late_count", 64'(late_count), 64'd0);

    $display("[TB] randomized packets");
    do_reset();
    for (int p = 0; p < 40; p++) begin
      logic [CW-1:0] ts;
      bp_mode   = $urandom_range(0, 1);
      late_drop = 1'($urandom_range(0, 1));
      idle($urandom_range(0, 3));
      ts = time_counter + 64'($urandom_range(0, 24)) - 64'd8;
      applyStimulus(ts, $urandom_range(1, 5), 1'b0, 5);
    end
    bp_mode = 0;
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
